// File: rtl/sls_rr_arb4_v_if.sv
// Requester/arbiter bundle for sls_rr_arb4_v: four request lines and data words
// in, one-hot grant, registered mux select and the registered selected word out.
interface sls_rr_arb4_v_if #(
  parameter int WIDTH = 8
);
  logic [3:0]       req;
  logic [WIDTH-1:0] d3;
  logic [WIDTH-1:0] d2;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d0;
  logic [3:0]       gnt;
  logic             s1;
  logic             s0;
  logic [WIDTH-1:0] f;
  logic             valid;

  modport master (
    output req, d3, d2, d1, d0,
    input  gnt, s1, s0, f, valid
  );

  modport slave (
    input  req, d3, d2, d1, d0,
    output gnt, s1, s0, f, valid
  );
endinterface

// File: rtl/sls_rr_arb4_v.sv
// Four-requester round-robin arbiter driving the 4:1 datapath mux select and a
// registered output word. Define SLS_ARB_HOLD_LIMIT_EN to cap ownership at HOLD_MAX cycles.
module sls_rr_arb4_v #(
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  sls_rr_arb4_v_if.slave      bus
);

  if (HOLD_MAX < 1) begin : g_bad_hold_max
    $error("HOLD_MAX must be at least 1");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] mux_out;
  logic             keep_owner;
  logic             hold_hit;
  logic             win_found;
  logic [1:0]       win_idx;

  // First set request bit at or after start, wrapping modulo 4.
  function automatic logic [2:0] rr_search(input logic [3:0] r, input logic [1:0] start);
    logic [1:0] idx;
    rr_search = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (r[idx]) rr_search = {1'b1, idx};
    end
  endfunction

`ifdef SLS_ARB_HOLD_LIMIT_EN
  localparam int CNT_W = $clog2(HOLD_MAX + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign hold_hit = (cnt_q == CNT_W'(HOLD_MAX));
`else
  assign hold_hit = 1'b0;
`endif

  always_comb begin
    case (sel_q)
      2'd0:    mux_out = bus.d0;
      2'd1:    mux_out = bus.d1;
      2'd2:    mux_out = bus.d2;
      default: mux_out = bus.d3;
    endcase
  end

  // In GRANT, ptr_q is always owner+1, so one search from ptr_q covers both
  // release and forced rotation, with the owner naturally last in line.
  assign {win_found, win_idx} = rr_search(bus.req, ptr_q);
  assign keep_owner = (state_q == GRANT) && bus.req[sel_q] && !hold_hit;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    valid_d = |gnt_q;
    f_d     = (|gnt_q) ? mux_out : f_q;
`ifdef SLS_ARB_HOLD_LIMIT_EN
    cnt_d   = cnt_q;
`endif
    if (keep_owner) begin
`ifdef SLS_ARB_HOLD_LIMIT_EN
      if (!hold_hit) cnt_d = cnt_q + 1'b1;
`endif
    end else if (win_found) begin
      state_d = GRANT;
      gnt_d   = 4'b0001 << win_idx;
      sel_d   = win_idx;
      ptr_d   = win_idx + 2'd1;
`ifdef SLS_ARB_HOLD_LIMIT_EN
      cnt_d   = CNT_W'(1);
`endif
    end else begin
      state_d = IDLE;
      gnt_d   = 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      f_q     <= '0;
      valid_q <= 1'b0;
`ifdef SLS_ARB_HOLD_LIMIT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      f_q     <= f_d;
      valid_q <= valid_d;
`ifdef SLS_ARB_HOLD_LIMIT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.s1    = sel_q[1];
  assign bus.s0    = sel_q[0];
  assign bus.f     = f_q;
  assign bus.valid = valid_q;

endmodule
